// File: rtl/imem_port_arbiter.sv
// Two-port arbiter sharing one byte-wide async-read program ROM; each request returns a big-endian 4-byte word.
// Optional IMEM_ARB_ALIGN_CHECK_EN: misaligned requests skip the ROM and answer with rsp_err=1.
module imem_port_arbiter #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  input  logic [A_WIDTH-1:0]   req_addr0,
  input  logic [A_WIDTH-1:0]   req_addr1,
  output logic [1:0]           req_ready,
  output logic [1:0]           rsp_valid,
  output logic [4*D_WIDTH-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 mem_en,
  output logic [A_WIDTH-1:0]   mem_addr,
  input  logic [D_WIDTH-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           cnt;
  logic [A_WIDTH-1:0]   base;
  logic                 gnt_id;
  logic                 rr_ptr;
  logic [4*D_WIDTH-1:0] word_buf;
  logic [4*D_WIDTH-1:0] rsp_data_q;

  logic [1:0]           grant;
  logic                 gnt_sel;
  logic                 accept;
  logic [A_WIDTH-1:0]   sel_addr;
  logic                 misaligned;

  // Grant is gated by rst_n so req_ready stays low while reset is held.
  always_comb begin
    grant   = 2'b00;
    gnt_sel = 1'b0;
    if (state == IDLE && rst_n) begin
      case (req_valid)
        2'b01: grant = 2'b01;
        2'b10: begin
          grant   = 2'b10;
          gnt_sel = 1'b1;
        end
        2'b11: begin
          gnt_sel = rr_ptr;
          grant   = rr_ptr ? 2'b10 : 2'b01;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_addr  = gnt_sel ? req_addr1 : req_addr0;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned = (sel_addr[1:0] != 2'b00);
  assign rsp_err    = (state == RESP) && err_q;
`else
  assign misaligned = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = misaligned ? RESP : READ;
      READ: if (cnt == 2'd3) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: latch the granted request, then collect one byte per READ cycle.
  // rsp_data only updates on the transition into RESP so it holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      base       <= '0;
      gnt_id     <= 1'b0;
      rr_ptr     <= 1'b0;
      word_buf   <= '0;
      rsp_data_q <= '0;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        base   <= sel_addr;
        gnt_id <= gnt_sel;
        rr_ptr <= ~gnt_sel;
        cnt    <= 2'd0;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        err_q  <= misaligned;
        if (misaligned) rsp_data_q <= '0;
`endif
      end
      if (state == READ) begin
        word_buf[(3 - int'(cnt))*D_WIDTH +: D_WIDTH] <= mem_rdata;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) rsp_data_q <= {word_buf[4*D_WIDTH-1:D_WIDTH], mem_rdata};
      end
    end
  end

  assign mem_en    = (state == READ);
  assign mem_addr  = (state == READ) ? base + {{(A_WIDTH-2){1'b0}}, cnt} : '0;
  assign rsp_valid = (state == RESP) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a small behavioural ROM.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  imem_port_arbiter #(.A_WIDTH(32), .D_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: fixed fetch word at 0xBFC00000, elsewhere byte = addr[7:0] ^ 0xA5.
  always_comb begin
    case (mem_addr)
      32'hBFC00000: mem_rdata = 8'h93;
      32'hBFC00001: mem_rdata = 8'h00;
      32'hBFC00002: mem_rdata = 8'h50;
      32'hBFC00003: mem_rdata = 8'h00;
      default:      mem_rdata = mem_addr[7:0] ^ 8'hA5;
    endcase
  end

  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] a1);
    req_valid = valid;
    req_addr0 = a0;
    req_addr1 = a1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from the grant cycle through the response cycle.
  task automatic runWord(input string tag, input logic [1:0] exp_port, input logic [31:0] exp_addr,
                         input logic [31:0] exp_word, input bit drop_after);
    logic [31:0] a;
    #1;
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'(exp_port));
    nextCycle();
    if (drop_after) req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      a = exp_addr + 32'(i);
      checkOutput({tag, "_mem_en"}, 64'(mem_en), 64'd1);
      checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'(a));
      checkOutput({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
      checkOutput({tag, "_early_rsp"}, 64'(rsp_valid), 64'd0);
      nextCycle();
    end
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(exp_port));
    checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_word));
    checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    checkOutput({tag, "_rsp_mem_en"}, 64'(mem_en), 64'd0);
    nextCycle();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(2'b11, 32'hBFC00000, 32'h00001000);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_mem_en", 64'(mem_en), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);

    applyStimulus(2'b00, 32'h0, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    #1;
    checkOutput("idle_no_req_ready", 64'(req_ready), 64'd0);
    nextCycle();

    $display("[TB] single fetch");
    applyStimulus(2'b01, 32'hBFC00000, 32'h0);
    runWord("fetch", 2'b01, 32'hBFC00000, 32'h93005000, 1'b1);
    checkOutput("fetch_pulse_end", 64'(rsp_valid), 64'd0);
    checkOutput("fetch_data_hold", 64'(rsp_data), 64'h93005000);

    $display("[TB] reset mid-read");
    applyStimulus(2'b10, 32'h0, 32'h00001000);
    #1;
    checkOutput("abort_ready", 64'(req_ready), 64'b10);
    nextCycle();
    applyStimulus(2'b00, 32'h0, 32'h0);
    nextCycle();
    checkOutput("abort_in_read", 64'(mem_en), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_en", 64'(mem_en), 64'd0);
    checkOutput("abort_mem_addr", 64'(mem_addr), 64'd0);
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("abort_no_rsp", 64'(rsp_valid), 64'd0);
      nextCycle();
    end

    $display("[TB] contention round-robin");
    applyStimulus(2'b11, 32'hBFC00000, 32'h00001000);
    runWord("rr0", 2'b01, 32'hBFC00000, 32'h93005000, 1'b0);
    runWord("rr1", 2'b10, 32'h00001000, 32'hA5A4A7A6, 1'b0);
    runWord("rr2", 2'b01, 32'hBFC00000, 32'h93005000, 1'b0);
    runWord("rr3", 2'b10, 32'h00001000, 32'hA5A4A7A6, 1'b0);

    $display("[TB] lone requester");
    applyStimulus(2'b10, 32'hBFC00000, 32'h00001000);
    runWord("lone0", 2'b10, 32'h00001000, 32'hA5A4A7A6, 1'b0);
    runWord("lone1", 2'b10, 32'h00001000, 32'hA5A4A7A6, 1'b0);
    runWord("lone2", 2'b10, 32'h00001000, 32'hA5A4A7A6, 1'b1);

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    $display("[TB] alignment check");
    applyStimulus(2'b01, 32'hBFC00002, 32'h0);
    #1;
    checkOutput("align_ready", 64'(req_ready), 64'b01);
    nextCycle();
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("align_mem_en", 64'(mem_en), 64'd0);
    checkOutput("align_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("align_rsp_valid", 64'(rsp_valid), 64'b01);
    checkOutput("align_rsp_err", 64'(rsp_err), 64'd1);
    checkOutput("align_rsp_data", 64'(rsp_data), 64'd0);
    nextCycle();
    checkOutput("align_pulse_end", 64'(rsp_valid), 64'd0);
    checkOutput("align_err_end", 64'(rsp_err), 64'd0);
    checkOutput("align_mem_en_idle", 64'(mem_en), 64'd0);
`else
    $display("[TB] address wrap");
    applyStimulus(2'b10, 32'h0, 32'hFFFFFFFE);
    runWord("wrap", 2'b10, 32'hFFFFFFFE, 32'h5B5AA5A4, 1'b1);
`endif

    nextCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
